conf_int_mac_seq_ctrl: RTL and testbench

Sequencer that runs one shared integer multiply-accumulate datapath over a job of LEN operand pairs, producing acc = init + sum(a_i*b_i), truncated to DATA_PATH_BITWIDTH.
- Accepts a job command, streams operand pairs over a valid/ready input, and returns the result over a valid/ready output.
- Sits between operand producers (buffers, DMA) and result consumers in the approximate-integer datapath.
- OP_BITWIDTH masks operand precision for accuracy/energy studies.

---
 rtl/conf_int_mac_seq_ctrl_pkg.sv | 29 ++
 rtl/conf_int_mac_seq_ctrl_int_mac_datapath.sv | 24 ++
 rtl/conf_int_mac_seq_ctrl.sv | 95 +++++++++
 tb/tb_conf_int_mac_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conf_int_mac_seq_ctrl_pkg.sv
// Shared definitions for the integer MAC sequencer.
// Holds the FSM state encoding, the operand-mask helper and the default widths.
package conf_int_mac_seq_ctrl_pkg;

   localparam int DEF_DATA_PATH_BITWIDTH = 16;
   localparam int DEF_OP_BITWIDTH        = 16;
   localparam int DEF_LEN_BITWIDTH       = 8;
   localparam int MASK_MAX_BITWIDTH      = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ACCUM = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Clears every bit at and above op_bits so reduced-precision studies see truncated operands.
   function automatic logic [MASK_MAX_BITWIDTH-1:0] op_mask(
      input logic [MASK_MAX_BITWIDTH-1:0] x,
      input int                           op_bits
   );
      logic [MASK_MAX_BITWIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_MAX_BITWIDTH; i++) begin
         if (i < op_bits) m[i] = 1'b1;
      end
      return x & m;
   endfunction

endpackage

// File: rtl/conf_int_mac_seq_ctrl_int_mac_datapath.sv
// Combinational multiply-accumulate slice: d = mask(a)*mask(b) + c, wrapped to the datapath width.
module int_mac_datapath
   import conf_int_mac_seq_ctrl_pkg::*;
#(
   parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
   parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH
) (
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   input  logic [DATA_PATH_BITWIDTH-1:0] c,
   output logic [DATA_PATH_BITWIDTH-1:0] d
);

   logic [DATA_PATH_BITWIDTH-1:0] a_m;
   logic [DATA_PATH_BITWIDTH-1:0] b_m;

   // Only the low bits of the product and sum are kept, so computing at the datapath width is exact.
   always_comb begin
      a_m = DATA_PATH_BITWIDTH'(op_mask(MASK_MAX_BITWIDTH'(a), OP_BITWIDTH));
      b_m = DATA_PATH_BITWIDTH'(op_mask(MASK_MAX_BITWIDTH'(b), OP_BITWIDTH));
      d   = a_m * b_m + c;
   end

endmodule

// File: rtl/conf_int_mac_seq_ctrl.sv
// Job sequencer: seeds an accumulator, streams LEN operand pairs through one shared MAC,
// then holds the result on a valid/ready output until it is taken.
module conf_int_mac_seq_ctrl
   import conf_int_mac_seq_ctrl_pkg::*;
#(
   parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
   parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH,
   parameter int LEN_BITWIDTH       = DEF_LEN_BITWIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [LEN_BITWIDTH-1:0]       len,
   input  logic [DATA_PATH_BITWIDTH-1:0] init,
   input  logic                          abort,
   output logic                          busy,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
   input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_PATH_BITWIDTH-1:0] out_d
);

   state_t                        state;
   state_t                        state_nxt;
   logic [DATA_PATH_BITWIDTH-1:0] acc;
   logic [DATA_PATH_BITWIDTH-1:0] acc_nxt;
   logic [LEN_BITWIDTH-1:0]       cnt;
   logic [LEN_BITWIDTH-1:0]       cnt_nxt;
   logic [DATA_PATH_BITWIDTH-1:0] mac_d;
   logic                          beat;

   int_mac_datapath #(
      .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH),
      .OP_BITWIDTH        (OP_BITWIDTH)
   ) u_mac (
      .a (in_a),
      .b (in_b),
      .c (acc),
      .d (mac_d)
   );

   // Handshake outputs depend on state only, so in_ready and out_valid can never overlap.
   assign busy      = (state != ST_IDLE);
   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = (state == ST_DONE);
   assign out_d     = (state == ST_DONE) ? acc : '0;
   assign beat      = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Abort outranks any same-cycle beat or result handshake and leaves acc untouched.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               acc_nxt   = init;
               cnt_nxt   = len;
               state_nxt = (len == '0) ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (beat) begin
               acc_nxt = mac_d;
               cnt_nxt = cnt - LEN_BITWIDTH'(1);
               if (cnt == LEN_BITWIDTH'(1)) state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (abort || out_ready) state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conf_int_mac_seq_ctrl.sv
// Self-checking bench: a 16-bit-operand build and an 8-bit-operand build share the same stimulus
// and are compared against a job-level reference of init + sum(mask(a)*mask(b)).
module tb_conf_int_mac_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic [15:0] init;
   logic        abort;
   logic        in_valid;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_ready;

   logic        busy, in_ready, out_valid;
   logic [15:0] out_d;
   logic        busy8, in_ready8, out_valid8;
   logic [15:0] out_d8;

   int checks;
   int failures;

   logic [15:0] pq_a[$];
   logic [15:0] pq_b[$];

   conf_int_mac_seq_ctrl #(
      .DATA_PATH_BITWIDTH (16),
      .OP_BITWIDTH        (16),
      .LEN_BITWIDTH       (8)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .len (len), .init (init), .abort (abort),
      .busy (busy), .in_valid (in_valid), .in_ready (in_ready), .in_a (in_a), .in_b (in_b),
      .out_valid (out_valid), .out_ready (out_ready), .out_d (out_d)
   );

   conf_int_mac_seq_ctrl #(
      .DATA_PATH_BITWIDTH (16),
      .OP_BITWIDTH        (8),
      .LEN_BITWIDTH       (8)
   ) dut8 (
      .clk (clk), .rst (rst), .start (start), .len (len), .init (init), .abort (abort),
      .busy (busy8), .in_valid (in_valid), .in_ready (in_ready8), .in_a (in_a), .in_b (in_b),
      .out_valid (out_valid8), .out_ready (out_ready), .out_d (out_d8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One accumulation step of the reference: operands truncated to w bits, result wrapped to 16 bits.
   function automatic logic [15:0] macRef(input logic [15:0] acc, input logic [15:0] a,
                                          input logic [15:0] b, input int w);
      int unsigned m;
      int unsigned p;
      m = (w >= 16) ? 32'h0000_FFFF : ((32'd1 << w) - 32'd1);
      p = (32'(a) & m) * (32'(b) & m) + 32'(acc);
      return p[15:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Runs one complete job; gap_mode 0 = in_valid held high, 1 = toggling, 2 = random gaps.
   task automatic runJob(input int n, input logic [15:0] ini, input int gap_mode, input int hold);
      logic [15:0] exp16, exp8, a, b, held;
      int sent, cyc;
      bit v;
      exp16 = ini;
      exp8  = ini;
      start = 1'b1;
      len   = 8'(n);
      init  = ini;
      applyStimulus();
      start = 1'b0;
      checkOutput("busy_after_start", {busy8, busy}, 2'b11);
      if (n == 0) begin
         checkOutput("len0_in_ready", {in_ready8, in_ready}, 2'b00);
      end else begin
         sent = 0;
         cyc  = 0;
         checkOutput("accum_in_ready", {in_ready8, in_ready}, 2'b11);
         while (sent < n && cyc < 1000) begin
            if (gap_mode == 0)      v = 1'b1;
            else if (gap_mode == 1) v = (cyc % 2 == 0);
            else                    v = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            if (v) begin
               if (pq_a.size() > 0) begin
                  a = pq_a.pop_front();
                  b = pq_b.pop_front();
               end
               exp16 = macRef(exp16, a, b, 16);
               exp8  = macRef(exp8, a, b, 8);
               sent++;
            end
            in_valid = v;
            in_a     = a;
            in_b     = b;
            applyStimulus();
            cyc++;
            if (sent < n) checkOutput("mid_job_no_out_valid", {out_valid, in_ready}, 2'b01);
         end
         in_valid = 1'b0;
         if (sent < n) checkOutput("beat_timeout", 32'(sent), 32'(n));
      end
      checkOutput("done_out_valid", {out_valid8, out_valid}, 2'b11);
      checkOutput("done_in_ready", {in_ready8, in_ready}, 2'b00);
      checkOutput("result16", 32'(out_d), 32'(exp16));
      checkOutput("result8", 32'(out_d8), 32'(exp8));
      held = out_d;
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         start     = 1'b1;
         len       = 8'($urandom);
         applyStimulus();
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
         checkOutput("bp_out_d_stable", 32'(out_d), 32'(held));
      end
      start     = 1'b0;
      out_ready = 1'b1;
      applyStimulus();
      out_ready = 1'b0;
      checkOutput("post_take_idle", {busy8, busy, out_valid}, 3'b000);
      checkOutput("post_take_out_d", 32'(out_d), 32'd0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      start     = 1'b0;
      len       = '0;
      init      = '0;
      abort     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;

      #3;
      checkOutput("reset_outputs", {busy, in_ready, out_valid}, 3'b000);
      checkOutput("reset_out_d", 32'(out_d), 32'd0);
      #10;
      rst = 1'b1;
      applyStimulus();
      checkOutput("idle_after_reset", {busy, in_ready, out_valid}, 3'b000);

      // Three back-to-back beats: 5 + 6 + 20 + 1 = 0x20.
      pq_a = '{16'd2, 16'd4, 16'd1};
      pq_b = '{16'd3, 16'd5, 16'd1};
      runJob(3, 16'd5, 0, 0);

      runJob(0, 16'h1234, 0, 0);

      // 0xFF*0x101 + 1 wraps to zero at full width.
      pq_a = '{16'h00FF};
      pq_b = '{16'h0101};
      runJob(1, 16'h0001, 0, 0);

      pq_a = '{16'd1, 16'd1, 16'd1, 16'd1};
      pq_b = '{16'd1, 16'd1, 16'd1, 16'd1};
      runJob(4, 16'h0000, 1, 0);

      pq_a = '{16'd7};
      pq_b = '{16'd9};
      runJob(1, 16'h0100, 0, 5);

      // Upper operand bits are dropped only in the 8-bit build.
      pq_a = '{16'h0103};
      pq_b = '{16'h0202};
      runJob(1, 16'h0000, 0, 0);

      // Abort colliding with a beat after one accepted pair.
      start = 1'b1; len = 8'd3; init = 16'h0055;
      applyStimulus();
      start = 1'b0; in_valid = 1'b1; in_a = 16'd3; in_b = 16'd4;
      applyStimulus();
      abort = 1'b1; in_a = 16'd9; in_b = 16'd9;
      applyStimulus();
      abort = 1'b0; in_valid = 1'b0;
      checkOutput("abort_accum_idle", {busy, in_ready, out_valid}, 3'b000);
      applyStimulus();
      checkOutput("abort_no_result", 32'(out_valid), 32'd0);

      pq_a = '{16'd2};
      pq_b = '{16'd2};
      runJob(1, 16'd7, 0, 0);

      // Abort in DONE wins over a same-cycle out_ready.
      start = 1'b1; len = 8'd0; init = 16'h0099;
      applyStimulus();
      start = 1'b0;
      checkOutput("done_before_abort", 32'(out_d), 32'h0099);
      abort = 1'b1; out_ready = 1'b1;
      applyStimulus();
      abort = 1'b0; out_ready = 1'b0;
      checkOutput("abort_done_idle", {busy, out_valid}, 2'b00);

      // Start has priority over abort while idle.
      start = 1'b1; abort = 1'b1; len = 8'd0; init = 16'h0042;
      applyStimulus();
      start = 1'b0; abort = 1'b0;
      checkOutput("idle_start_over_abort", {busy, out_valid}, 2'b11);
      checkOutput("idle_start_over_abort_d", 32'(out_d), 32'h0042);
      out_ready = 1'b1;
      applyStimulus();
      out_ready = 1'b0;

      // Asynchronous reset in the middle of a job.
      start = 1'b1; len = 8'd5; init = 16'h0010;
      applyStimulus();
      start = 1'b0; in_valid = 1'b1; in_a = 16'd3; in_b = 16'd3;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("midjob_reset_flags", {busy, in_ready, out_valid}, 3'b000);
      checkOutput("midjob_reset_out_d", 32'(out_d), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus();
      checkOutput("after_reset_idle", 32'(busy), 32'd0);

      for (int j = 0; j < 25; j++) begin
         runJob(int'($urandom_range(0, 6)), 16'($urandom), 2, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
